// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, loads the IF/ID register, redirects on
// MEM-stage jumps, honours decode stalls, detects HALT and counts taken jumps.
module fetch_unit #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [4:0]      HALT_OP  = 5'h1F
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    output logic [PC_W-1:0] i_addr,
    input  logic [15:0]     i_datain,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    input  logic            stall,
    output logic [15:0]     id_ir,
    output logic [PC_W-1:0] id_pc,
    output logic            flush,
    output logic            halted,
    output logic [15:0]     jump_count
);

    localparam logic [15:0] NOP = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [PC_W-1:0] pc, pc_next;
    logic [PC_W-1:0] id_pc_next;
    logic [15:0]     id_ir_next;
    logic [15:0]     jump_count_next;

    // Reset is active-low and asynchronous even though the port is named reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            pc         <= RESET_PC;
            id_ir      <= NOP;
            id_pc      <= '0;
            jump_count <= '0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            id_ir      <= id_ir_next;
            id_pc      <= id_pc_next;
            jump_count <= jump_count_next;
        end
    end

    always_comb begin
        state_next      = state;
        pc_next         = pc;
        id_ir_next      = id_ir;
        id_pc_next      = id_pc;
        jump_count_next = jump_count;

        unique case (state)
            ST_IDLE: begin
                id_ir_next = NOP;
                if (enable) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                    id_ir_next = NOP;
                end else if (jump) begin
                    // A HALT sitting in id_ir is wrong-path when a jump lands.
                    pc_next    = jump_target;
                    id_ir_next = NOP;
                    id_pc_next = '0;
                    if (jump_count != 16'hFFFF) jump_count_next = jump_count + 16'd1;
                end else if (stall) begin
                    pc_next = pc;
                end else if (id_ir[15:11] == HALT_OP) begin
                    state_next = ST_HALT;
                    id_ir_next = NOP;
                end else begin
                    id_ir_next = i_datain;
                    id_pc_next = pc;
                    pc_next    = pc + 1'b1;
                end
            end
            ST_HALT: begin
                id_ir_next = NOP;
                if (!enable) state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                id_ir_next = NOP;
            end
        endcase
    end

    assign i_addr = pc;
    assign flush  = (state == ST_RUN) && jump;
    assign halted = (state == ST_HALT);

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 16-bit pipeline. Holds the program counter, drives the instruction-memory address and loads the IF/ID instruction register. It consumes the `jump` decision and target resolved in the MEM stage to redirect the PC and flush wrong-path instructions. It also honours decode-stage stalls, detects `HALT`, and keeps a saturating count of taken jumps.

## Interface
- `PC_W`, 8, width of the PC and instruction-memory address.
- `RESET_PC`, 0, PC value loaded on reset.
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `enable` in 1: run request, level-sensitive.
- `i_addr` out PC_W: instruction-memory address, equal to `pc` (combinational from the register).
- `i_datain` in 16: instruction word at `i_addr`; memory read is combinational.
- `jump` in 1: MEM-stage branch/jump taken.
- `jump_target` in PC_W: MEM-stage target address; valid when `jump`=1.
- `stall` in 1: decode-stage hazard stall.
- `id_ir` out 16: IF/ID instruction register.
- `id_pc` out PC_W: PC of the instruction in `id_ir`.
- `flush` out 1: combinational, equals `jump` while in RUN; downstream ID/EX registers clear on it.
- `halted` out 1: high in HALT state.
- `jump_count` out 16: number of taken jumps since reset, saturating.

## Operation
- States: IDLE, RUN, HALT. Reset enters IDLE.
- IDLE:
  - `pc` and `id_pc` hold; `id_ir` is loaded with NOP (16'h0000).
  - `enable`=1 moves to RUN on the next edge. No fetch happens on that edge.
- RUN, priority jump > stall > halt detect > normal:
  - jump: `pc` <= `jump_target`, `id_ir` <= NOP, `id_pc` <= 0, `jump_count` += 1 (saturates at 16'hFFFF). Stall and HALT detection are ignored that cycle, because any `HALT` in `id_ir` is on the wrong path.
  - stall: `pc`, `id_ir` and `id_pc` all hold.
  - `id_ir[15:11]` == `HALT` (from define.v): go to HALT. `pc` holds, `id_ir` <= NOP.
  - normal: `id_ir` <= `i_datain`, `id_pc` <= `pc`, `pc` <= `pc`+1. The PC wraps modulo 2^PC_W, so all-ones goes to 0.
- HALT:
  - `pc` holds; `id_ir` is loaded with NOP; `jump` and `stall` are ignored; `flush`=0.
  - Leaves HALT only via reset or `enable`=0.
- `enable`=0 in RUN or HALT: go to IDLE on the next edge. `pc` holds (no increment); `id_ir` <= NOP.
- A later `enable`=1 resumes fetching from the held `pc`.
- `flush` is 0 outside RUN.

## Timing
- Reset values: `pc`=RESET_PC, `i_addr`=RESET_PC, `id_ir`=16'h0000, `id_pc`=0, `halted`=0, `jump_count`=0, `flush`=0, state IDLE.
- Reset asserted mid-RUN clears everything asynchronously, with no clock edge needed. Release is sampled on the next rising edge.
- `enable` rises before edge E0: RUN from E0. The first instruction (at RESET_PC) appears in `id_ir` after edge E1.
- Fetch latency: the word at `i_addr` during cycle k is in `id_ir` in cycle k+1.
- `jump` sampled at edge E: `i_addr`=`jump_target` after E. The target instruction is in `id_ir` after E+1. Exactly one NOP bubble enters `id_ir`.
- `halted` rises one cycle after `HALT` reaches `id_ir` with no jump or stall.
- `stall` and `jump` asserted together: the jump wins; the stall is dropped.

## Test plan
- Reset then `enable`=1, memory[i]=16'h1000+i: `id_ir` = 16'h1000, 16'h1001, 16'h1002 on consecutive cycles; `id_pc` = 0, 1, 2.
- `jump`=1 with `jump_target`=8'h40 while `pc`=8'h05: next `i_addr`=8'h40, `id_ir`=NOP for one cycle, then the word at 8'h40. `flush`=1 during the jump cycle; `jump_count`=1.
- `stall` held for 3 cycles at `pc`=8'h10: `i_addr`, `id_ir` and `id_pc` frozen for 3 cycles, then fetch resumes with 8'h10 → `id_pc`.
- `HALT` in `id_ir` with no jump: `halted`=1 next cycle and `pc` frozen. Same case with `jump`=1 in that cycle: no halt, PC redirected.
- `pc`=8'hFF normal fetch: next `pc`=8'h00. Then 65536 forced jumps: `jump_count` holds at 16'hFFFF.
- Reset pulsed low mid-RUN at `pc`=8'h23: all outputs return to reset values immediately, and the block stays IDLE until `enable`.
